// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory stage: bus-level constants, RISC-V
// load/store funct3 encodings, FSM state type and the alignment rule.
package mem_access_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic ENABLE    = 1'b1;

  localparam int unsigned DATA_W = 32;
  typedef logic [DATA_W-1:0] data_t;
  localparam data_t DATA_ZERO = '0;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  typedef enum logic {
    S_IDLE,
    S_LOAD_WAIT
  } state_e;

  // Halfword accesses need addr[0] clear, word accesses need addr[1:0] clear.
  // Byte accesses and illegal funct3 values are never misaligned.
  function automatic logic is_misaligned(logic rw, logic [2:0] f3, logic [1:0] off);
    logic m;
    m = 1'b0;
    if (rw == MEM_READ) begin
      case (f3)
        F3_LH, F3_LHU: m = off[0];
        F3_LW:         m = |off;
        default:       m = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_SH:   m = off[0];
        F3_SW:   m = |off;
        default: m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_access_load_formatter.sv
// Load data formatter: selects the byte/halfword addressed by the captured
// offset and sign- or zero-extends it according to funct3.
//   rdata_i  : raw 32-bit RAM word
//   funct3_i : load funct3
//   offset_i : byte offset within the word
//   data_o   : extended load result (zero for unknown funct3)
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h000000, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0000, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = DATA_ZERO;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory stage: converts EX load/store requests into synchronous RAM
// accesses with byte enables and returns formatted load data one cycle later.
//   clk, rst            : clock, synchronous active-low reset
//   ex_valid/ex_mem_ena : EX instruction valid / accesses memory
//   mem_rw_i, mem_funct3_i, mem_addr_i, mem_wdata_i : access description
//   mem_rw_o            : direction of the last accepted access
//   mem_rdata_o         : formatted load data (valid in LOAD_WAIT)
//   misalign_o          : one-cycle pulse for a suppressed misaligned access
//   ram_*               : synchronous RAM interface
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned RAM_AW      = 14,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_ena,
  input  logic              mem_rw_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_rw_o,
  output logic [31:0]       mem_rdata_o,
  output logic              misalign_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_wmask_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  input  logic [31:0]       ram_rdata_i
);

  state_e     state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic [1:0] off_q, off_d;
  logic       rw_q, rw_d;
  logic       misalign_q, misalign_d;

  logic       access, misal, accept;
  logic [31:0] fmt_data;

  // Address bits above the RAM range are intentionally dropped (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr_i[31:RAM_AW+2];

  assign ram_addr_o = mem_addr_i[RAM_AW+1:2];

  always_comb begin
    access = ex_valid && (ex_mem_ena == ENABLE) && (state_q == S_IDLE);
    misal  = CHECK_ALIGN && is_misaligned(mem_rw_i, mem_funct3_i, mem_addr_i[1:0]);
    accept = access && !misal;
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rw_d        = rw_q;
    misalign_d  = 1'b0;
    ram_re_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_wmask_o = '0;

    case (state_q)
      S_IDLE: begin
        misalign_d = access && misal;
        if (accept) begin
          rw_d = mem_rw_i;
          if (mem_rw_i == MEM_READ) begin
            ram_re_o = 1'b1;
            funct3_d = mem_funct3_i;
            off_d    = mem_addr_i[1:0];
            state_d  = S_LOAD_WAIT;
          end else begin
            case (mem_funct3_i)
              F3_SB:   ram_wmask_o = 4'b0001 << mem_addr_i[1:0];
              F3_SH:   ram_wmask_o = 4'b0011 << {mem_addr_i[1], 1'b0};
              F3_SW:   ram_wmask_o = 4'b1111;
              default: ram_wmask_o = '0;
            endcase
            ram_we_o = |ram_wmask_o;
          end
        end
      end
      // Single-cycle wait: EX still shows the stalled load, which must not
      // be re-issued, so no strobes here and unconditionally back to IDLE.
      S_LOAD_WAIT: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (!rst) begin
      ram_re_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_wmask_o = '0;
    end
  end

  always_comb begin
    case (mem_funct3_i)
      F3_SB:   ram_wdata_o = {4{mem_wdata_i[7:0]}};
      F3_SH:   ram_wdata_o = {2{mem_wdata_i[15:0]}};
      default: ram_wdata_o = mem_wdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      funct3_q   <= '0;
      off_q      <= '0;
      rw_q       <= MEM_READ;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      rw_q       <= rw_d;
      misalign_q <= misalign_d;
    end
  end

  load_formatter u_fmt (
    .rdata_i  (ram_rdata_i),
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .data_o   (fmt_data)
  );

  assign mem_rw_o    = rw_q;
  assign misalign_o  = misalign_q;
  assign mem_rdata_o = (state_q == S_LOAD_WAIT) ? fmt_data : DATA_ZERO;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int unsigned AW     = 6;
  localparam int unsigned NBYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_ena, mem_rw_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        mem_rw_o, misalign_o, ram_we_o, ram_re_o;
  logic [31:0] mem_rdata_o, ram_wdata_o, ram_rdata;
  logic [3:0]  ram_wmask_o;
  logic [AW-1:0] ram_addr_o;

  int checks = 0;
  int failures = 0;

  // Environment RAM driven by the DUT strobes
  logic [31:0] ram_q [1 << AW];
  // Reference memory, byte-addressed
  logic [7:0]  ref_mem [NBYTES];
  logic        last_rw;

  always #5 clk = ~clk;

  mem_access #(.RAM_AW(AW), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena),
    .mem_rw_i(mem_rw_i), .mem_funct3_i(mem_funct3_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rw_o(mem_rw_o), .mem_rdata_o(mem_rdata_o),
    .misalign_o(misalign_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_wmask_o(ram_wmask_o), .ram_we_o(ram_we_o), .ram_re_o(ram_re_o),
    .ram_rdata_i(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we_o)
      for (int l = 0; l < 4; l++)
        if (ram_wmask_o[l]) ram_q[ram_addr_o][8*l +: 8] <= ram_wdata_o[8*l +: 8];
    if (ram_re_o) ram_rdata <= ram_q[ram_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned b, n;
    logic [31:0] v;
    b = addr % NBYTES;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    return 32'h0;
    endcase
    v = 0;
    for (int i = 0; i < int'(n); i++) v = v + (32'(ref_mem[(b + i) % NBYTES]) << (8 * i));
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // One access: drive in the low phase, check strobes, then check the
  // registered/returned results after the edge. idle_after inserts a bubble.
  task automatic do_access(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit idle_after);
    bit legal_ld, legal_st, mis, accepted;
    int unsigned sz;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata, exp_ld;
    legal_ld = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    legal_st = (f3 inside {3'd0, 3'd1, 3'd2});
    sz = 1 << f3[1:0];
    mis = ((rw == 1'b0) ? legal_ld : legal_st) && (addr % sz != 0);
    accepted = !mis;
    exp_mask = 4'b0000;
    if (rw && accepted && legal_st) exp_mask = 4'((1 << sz) - 1) << (addr % 4);
    case (sz)
      1:       exp_wdata = (wd & 32'hFF) * 32'h01010101;
      2:       exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
      default: exp_wdata = wd;
    endcase

    @(negedge clk);
    ex_valid = 1'b1; ex_mem_ena = 1'b1; mem_rw_i = rw;
    mem_funct3_i = f3; mem_addr_i = addr; mem_wdata_i = wd;
    #1;
    chk("re", 32'(ram_re_o), 32'(!rw && accepted));
    chk("we", 32'(ram_we_o), 32'(rw && accepted && legal_st));
    if (rw) chk("wmask", 32'(ram_wmask_o), 32'(exp_mask));
    if (rw && accepted && legal_st) chk("wdata", ram_wdata_o, exp_wdata);
    if (accepted) chk("addr", 32'(ram_addr_o), (addr >> 2) % (1 << AW));

    exp_ld = ref_load(f3, addr);
    if (accepted) begin
      last_rw = rw;
      if (rw && legal_st)
        for (int i = 0; i < int'(sz); i++)
          ref_mem[(addr + i) % NBYTES] = 8'((wd >> (8 * i)) & 32'hFF);
    end

    @(posedge clk); #1;
    chk("rw_o", 32'(mem_rw_o), 32'(last_rw));
    chk("misalign", 32'(misalign_o), 32'(mis));
    if (!rw && accepted) begin
      chk("load", mem_rdata_o, exp_ld);
      chk("re_hold", 32'(ram_re_o), 32'h0);
      chk("we_hold", 32'(ram_we_o), 32'h0);
      @(negedge clk); ex_valid = 1'b0;
      @(posedge clk); #1;
      chk("rdata_idle", mem_rdata_o, 32'h0);
    end else begin
      chk("rdata_zero", mem_rdata_o, 32'h0);
      if (idle_after) begin
        @(negedge clk); ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("misalign_pulse", 32'(misalign_o), 32'h0);
      end
    end
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_q[i] = '0;
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = '0;
    ram_rdata = '0;
    last_rw = 1'b0;

    // Reset with a live load request presented: strobes must stay low
    rst = 1'b0; ex_valid = 1'b1; ex_mem_ena = 1'b1; mem_rw_i = 1'b0;
    mem_funct3_i = 3'd2; mem_addr_i = 32'h10; mem_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_re", 32'(ram_re_o), 32'h0);
    chk("rst_we", 32'(ram_we_o), 32'h0);
    chk("rst_rw", 32'(mem_rw_o), 32'h0);
    chk("rst_rdata", mem_rdata_o, 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'h0);
    @(negedge clk); rst = 1'b1; ex_valid = 1'b0;

    // Directed sequence
    do_access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
    do_access(1'b0, 3'd0, 32'h13, 32'h0, 1);
    chk("lb_value_ref", ref_load(3'd0, 32'h13), 32'hFFFFFFDE);
    do_access(1'b0, 3'd4, 32'h13, 32'h0, 1);
    do_access(1'b1, 3'd1, 32'h12, 32'h00001234, 1);
    do_access(1'b0, 3'd1, 32'h12, 32'h0, 1);
    do_access(1'b0, 3'd2, 32'h11, 32'h0, 1);
    do_access(1'b1, 3'd4, 32'h14, 32'h55, 1);
    do_access(1'b0, 3'd3, 32'h10, 32'h0, 1);
    do_access(1'b1, 3'd0, 32'h15, 32'h77, 1);

    // Reset while a load waits for data
    do_access(1'b1, 3'd2, 32'h30, 32'h13579BDF, 1);
    @(negedge clk);
    ex_valid = 1'b1; mem_rw_i = 1'b0; mem_funct3_i = 3'd2; mem_addr_i = 32'h30;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rstw_re", 32'(ram_re_o), 32'h0);
    @(posedge clk); #1;
    last_rw = 1'b0;
    chk("rstw_rdata", mem_rdata_o, 32'h0);
    chk("rstw_rw", 32'(mem_rw_o), 32'h0);
    @(negedge clk); rst = 1'b1; ex_valid = 1'b0;
    do_access(1'b0, 3'd2, 32'h30, 32'h0, 1);

    // Back-to-back store then load of the same word
    do_access(1'b1, 3'd2, 32'h20, 32'hA5A5A5A5, 0);
    do_access(1'b0, 3'd2, 32'h20, 32'h0, 1);

    // Randomized traffic, including high address bits that must wrap
    for (int n = 0; n < 150; n++) begin
      logic [31:0] r, a;
      logic rw;
      r  = $urandom();
      a  = {r[31:8], 2'b00, r[5:0]};
      rw = 1'($urandom_range(0, 1));
      if (rw) do_access(1'b1, st_f3[$urandom_range(0, 2)], a, $urandom(), ($urandom_range(0, 3) != 0));
      else    do_access(1'b0, ld_f3[$urandom_range(0, 4)], a, 32'h0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Data-memory stage between EX and the write-back merge logic. It turns EX load/store requests into synchronous-RAM accesses with byte enables.
- Loaded data is aligned and sign- or zero-extended, then presented as mem_rdata_o together with mem_rw_o.
- A load takes one extra cycle: the request is issued in the EX cycle and the formatted data is returned in the following cycle, which the downstream stall logic covers.
- Misaligned accesses are suppressed and flagged.

Parameters:
- RAM_AW, 14, RAM word-address width (RAM depth = 2^RAM_AW words of 32 bits).
- CHECK_ALIGN, 1, 1 = detect and suppress misaligned LH/LHU/LW/SH/SW; 0 = ignore the low address bits for those accesses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_valid  in  1  EX holds a valid instruction.
- ex_mem_ena  in  1  `ENABLE when the instruction accesses memory.
- mem_rw_i  in  1  `MEM_READ or `MEM_WRITE.
- mem_funct3_i  in  3  RISC-V funct3 of the load/store.
- mem_addr_i  in  32  byte address from the ALU.
- mem_wdata_i  in  `DATA_BUS  store data (rs2).
- mem_rw_o  out  1  registered copy of mem_rw_i for the accepted access.
- mem_rdata_o  out  `DATA_BUS  formatted load data.
- misalign_o  out  1  one-cycle pulse on a suppressed misaligned access.
- ram_addr_o  out  RAM_AW  word address (mem_addr_i[RAM_AW+1:2]).
- ram_wdata_o  out  32  store data replicated into byte lanes.
- ram_wmask_o  out  4  byte write enables.
- ram_we_o  out  1  write strobe.
- ram_re_o  out  1  read strobe.
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_re_o.

Behaviour:
- State machine with two states, IDLE and LOAD_WAIT. Reset state is IDLE.
- Reset values (rst low at a clock edge):
  - mem_rw_o = `MEM_READ, mem_rdata_o = `DATA_ZERO, misalign_o = 0.
  - Captured funct3 and offset registers = 0.
  - While rst is low, ram_we_o and ram_re_o are forced to 0 combinationally.
- A request is a cycle with ex_valid && ex_mem_ena == `ENABLE while in IDLE, and the access is not misaligned.
- Load request in IDLE:
  - Same cycle (combinational): ram_re_o = 1 and ram_addr_o driven.
  - At the clock edge: capture funct3 and addr[1:0], set mem_rw_o = `MEM_READ, go to LOAD_WAIT.
- LOAD_WAIT, occupancy exactly one cycle:
  - ram_re_o = 0 and ram_we_o = 0, even though EX still presents the same instruction (no re-issue).
  - mem_rdata_o is combinational from ram_rdata_i and the captured fields:
    - LB: sign-extended byte at offset.
    - LBU: zero-extended byte at offset.
    - LH: sign-extended halfword at offset[1].
    - LHU: zero-extended halfword at offset[1].
    - LW: full word.
    - Any other funct3: `DATA_ZERO.
  - Next edge: return to IDLE, so the stalled instruction is not treated as a new request.
- Store request in IDLE:
  - Combinational: ram_we_o = 1, ram_wmask_o = SB 0001<<off, SH 0011<<(2*off[1]), SW 1111.
  - ram_wdata_o = the byte or halfword replicated across all lanes (SW passes the word through).
  - The RAM commits at the end of the same cycle; there is no stall and the state stays IDLE.
  - mem_rw_o = `MEM_WRITE registered.
- Illegal store funct3: wmask = 0000 and ram_we_o = 0.
- Misaligned access (CHECK_ALIGN = 1): LH/LHU/SH with addr[0] set, or LW/SW with addr[1:0] != 0.
  - No RAM strobes.
  - misalign_o = 1 on the next cycle for one cycle.
  - The state stays IDLE; mem_rdata_o reads `DATA_ZERO.
- When not in LOAD_WAIT, mem_rdata_o = `DATA_ZERO.
- Store followed immediately by a load to the same word: correct by construction, because the write lands at edge N and the read address is sampled at edge N+1.
- Reset asserted during LOAD_WAIT: return to IDLE and discard the pending data.
- Address bits above RAM_AW+1 are ignored, so accesses wrap within the RAM.

Decomposition:
- Put funct3 encodings (LB..LHU, SB..SW) and the state encodings in common.v, next to `MEM_READ/`MEM_WRITE, `DATA_BUS and `DATA_ZERO.
- One combinational sub-module, load_formatter (inputs: rdata, funct3, offset; output: extended data), so it can be unit-tested on its own.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF:
  - Cycle 0: ram_we_o = 1, wmask = 1111, ram_addr_o = 4, ram_re_o = 0.
  - Next cycle: mem_rw_o = `MEM_WRITE, misalign_o = 0.
- LB then LBU at 0x13 after the SW:
  - Request cycle: ram_re_o = 1.
  - Following cycle: mem_rdata_o = 0xFFFFFFDE (LB), then 0x000000DE (LBU).
  - The held duplicate cycle produces ram_re_o = 0.
- SH at 0x12 with data 0x00001234:
  - wmask = 1100, ram_wdata_o = 0x12341234.
  - A subsequent LH at 0x12 returns 0x00001234.
- LW at 0x11:
  - No strobes, misalign_o pulses 1 for one cycle, mem_rdata_o = 0, state stays IDLE.
- rst low during LOAD_WAIT:
  - Next cycle: state IDLE, mem_rdata_o = 0, mem_rw_o = `MEM_READ.
  - A fresh LW afterwards completes normally.
- Back-to-back: SW 0x20 = 0xA5A5A5A5 then LW 0x20 in the next cycle:
  - The LW returns 0xA5A5A5A5 one cycle after its request.
